// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default clock/baud
// settings and the clocks-per-bit derivation used by uart_send and uart_recv.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50000000;
  localparam int UART_BPS_DEF = 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector on the synchronised signal. All flops reset to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_s,
  output logic fall
);

  logic rx_s1;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: oversamples the line at the system clock, samples each
// bit at its centre and strobes uart_done with the byte or frame_err on a bad stop bit.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int UART_BPS = UART_BPS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BPS_CNT - 1);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_s, fall;
  logic             mid_hit, end_hit;
  logic             done_next, ferr_next;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (uart_rxd),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign mid_hit = (clk_cnt == CNT_MID);
  assign end_hit = (clk_cnt == CNT_END);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    unique case (state)
      IDLE:  if (fall) state_next = START;
      START: if (mid_hit) state_next = rx_s ? IDLE : DATA;
      DATA:  if (end_hit && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (end_hit) begin
          state_next = IDLE;
          done_next  = rx_s;
          ferr_next  = ~rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      uart_data <= 8'h00;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      uart_done <= done_next;
      frame_err <= ferr_next;
      if (done_next) uart_data <= shift;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        START: begin
          clk_cnt <= mid_hit ? '0 : clk_cnt + 1'b1;
          bit_idx <= '0;
        end
        DATA: begin
          clk_cnt <= end_hit ? '0 : clk_cnt + 1'b1;
          if (end_hit) bit_idx <= bit_idx + 3'd1;
        end
        STOP:    clk_cnt <= end_hit ? '0 : clk_cnt + 1'b1;
        default: clk_cnt <= '0;
      endcase
    end
  end

  // Byte assembly register: no reset needed, only read after a full frame.
  always_ff @(posedge clk) begin
    if (state == DATA && end_hit) shift[bit_idx] <= rx_s;
  end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv at a reduced clocks-per-bit ratio (50) so that many
// frames fit in a short run; expectations come from frame-level rules.
module tb_uart_recv;

  localparam int CLK_FREQ = 500000;
  localparam int UART_BPS = 10000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int LAT      = 9 * BPS + BPS / 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] done_q[$];
  int         done_t[$];
  int         ferr_n = 0;
  int         both_n = 0;
  logic [7:0] last_good = 8'h00;

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .uart_data (uart_data),
    .uart_done (uart_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_done) begin
      done_q.push_back(uart_data);
      done_t.push_back(cyc);
    end
    if (frame_err) ferr_n = ferr_n + 1;
    if (uart_done && frame_err) both_n = both_n + 1;
  end

  task automatic clear_mon();
    done_q.delete();
    done_t.delete();
    ferr_n = 0;
    both_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line back high.
  task automatic send_frame(input logic [7:0] b, input int bitlen,
                            input logic stop_v, output int t0);
    uart_rxd = 1'b0;
    t0 = cyc;
    repeat (bitlen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (bitlen) @(negedge clk);
    end
    uart_rxd = stop_v;
    repeat (bitlen) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rxd = 1'b1;
    idle(5);
    checks++;
    if (uart_data !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %h want 00", uart_data);
    end
    checks++;
    if (uart_done !== 1'b0) begin
      failures++; $display("FAIL reset_done: got %b want 0", uart_done);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_ferr: got %b want 0", frame_err);
    end
    rst_n = 1'b1;
    clear_mon();
    idle(20 * BPS);
    checks++;
    if (done_q.size() != 0) begin
      failures++; $display("FAIL reset_idle_done: got %0d strobes want 0", done_q.size());
    end
    checks++;
    if (ferr_n != 0) begin
      failures++; $display("FAIL reset_idle_ferr: got %0d want 0", ferr_n);
    end
  endtask

  task automatic test_single_byte();
    int t0a, t0b;
    clear_mon();
    send_frame(8'h55, BPS, 1'b1, t0a);
    idle(BPS);
    send_frame(8'hA3, BPS, 1'b1, t0b);
    idle(2 * BPS);
    checks++;
    if (done_q.size() != 2) begin
      failures++; $display("FAIL single_count: got %0d want 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] !== 8'h55) begin
        failures++; $display("FAIL single_b0: got %h want 55", done_q[0]);
      end
      checks++;
      if (done_q[1] !== 8'hA3) begin
        failures++; $display("FAIL single_b1: got %h want a3", done_q[1]);
      end
      checks++;
      if (done_t[0] - t0a < LAT - 2 || done_t[0] - t0a > LAT + 2) begin
        failures++; $display("FAIL single_latency: got %0d want %0d+-2", done_t[0] - t0a, LAT);
      end
      checks++;
      if (done_t[1] - t0b < LAT - 2 || done_t[1] - t0b > LAT + 2) begin
        failures++; $display("FAIL single_latency2: got %0d want %0d+-2", done_t[1] - t0b, LAT);
      end
    end
    checks++;
    if (ferr_n != 0) begin
      failures++; $display("FAIL single_ferr: got %0d want 0", ferr_n);
    end
    checks++;
    if (uart_data !== 8'hA3) begin
      failures++; $display("FAIL single_hold: got %h want a3", uart_data);
    end
    last_good = 8'hA3;
  endtask

  task automatic test_glitch();
    int t0;
    clear_mon();
    uart_rxd = 1'b0;
    idle(BPS / 2 - 6);
    uart_rxd = 1'b1;
    idle(BPS / 2 + 10);
    checks++;
    if (done_q.size() != 0 || ferr_n != 0) begin
      failures++;
      $display("FAIL glitch_strobe: got done=%0d ferr=%0d want 0/0", done_q.size(), ferr_n);
    end
    send_frame(8'h6B, BPS, 1'b1, t0);
    idle(BPS);
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 8'h6B) begin
      failures++; $display("FAIL glitch_recover: got %0d strobes data %h want 1 of 6b",
                           done_q.size(), uart_data);
    end
    last_good = 8'h6B;
  endtask

  task automatic test_framing_error();
    int t0;
    clear_mon();
    send_frame(8'h3C, BPS, 1'b0, t0);
    idle(BPS);
    checks++;
    if (ferr_n != 1) begin
      failures++; $display("FAIL frame_err_count: got %0d want 1", ferr_n);
    end
    checks++;
    if (done_q.size() != 0) begin
      failures++; $display("FAIL frame_err_done: got %0d want 0", done_q.size());
    end
    checks++;
    if (uart_data !== last_good) begin
      failures++; $display("FAIL frame_err_hold: got %h want %h", uart_data, last_good);
    end
    send_frame(8'h81, BPS, 1'b1, t0);
    idle(BPS);
    checks++;
    if (done_q.size() != 1 || uart_data !== 8'h81 || ferr_n != 1) begin
      failures++; $display("FAIL frame_err_next: got n=%0d data=%h ferr=%0d want 1/81/1",
                           done_q.size(), uart_data, ferr_n);
    end
    last_good = 8'h81;
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    clear_mon();
    send_frame(8'h00, BPS, 1'b1, t0a);
    send_frame(8'hFF, BPS, 1'b1, t0b);
    idle(2 * BPS);
    checks++;
    if (done_q.size() != 2) begin
      failures++; $display("FAIL b2b_count: got %0d want 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] !== 8'h00 || done_q[1] !== 8'hFF) begin
        failures++; $display("FAIL b2b_data: got %h %h want 00 ff", done_q[0], done_q[1]);
      end
      checks++;
      if (done_t[1] - done_t[0] < 10 * BPS - 2 || done_t[1] - done_t[0] > 10 * BPS + 2) begin
        failures++; $display("FAIL b2b_spacing: got %0d want %0d+-2",
                             done_t[1] - done_t[0], 10 * BPS);
      end
    end
    last_good = 8'hFF;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int t0;
    b = 8'h5A;
    clear_mon();
    uart_rxd = 1'b0;
    idle(BPS);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      idle(BPS);
    end
    uart_rxd = b[4];
    idle(BPS / 2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    checks++;
    if (uart_data !== 8'h00) begin
      failures++; $display("FAIL midrst_data: got %h want 00", uart_data);
    end
    uart_rxd = 1'b1;
    idle(BPS / 2 + BPS);
    send_frame(8'h96, BPS, 1'b1, t0);
    idle(BPS);
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 8'h96) begin
      failures++; $display("FAIL midrst_result: got %0d strobes data %h want 1 of 96",
                           done_q.size(), uart_data);
    end
    checks++;
    if (ferr_n != 0) begin
      failures++; $display("FAIL midrst_ferr: got %0d want 0", ferr_n);
    end
    last_good = 8'h96;
  endtask

  task automatic test_random_frames();
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] b;
    logic       bad;
    int         bitlen, t0;
    exp_err = 0;
    clear_mon();
    for (int n = 0; n < 14; n++) begin
      b      = 8'($urandom);
      bitlen = BPS - 1 + int'($urandom_range(0, 2));
      bad    = ($urandom_range(0, 4) == 0);
      send_frame(b, bitlen, ~bad, t0);
      if (bad) begin
        exp_err++;
        idle(BPS);
      end else begin
        exp_q.push_back(b);
        last_good = b;
        idle(int'($urandom_range(0, BPS)));
      end
    end
    idle(2 * BPS);
    checks++;
    if (done_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d want %0d", done_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (done_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_byte%0d: got %h want %h", i, done_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ferr_n != exp_err) begin
      failures++; $display("FAIL rand_ferr: got %0d want %0d", ferr_n, exp_err);
    end
    checks++;
    if (both_n != 0) begin
      failures++; $display("FAIL rand_overlap: got %0d want 0", both_n);
    end
    checks++;
    if (uart_data !== last_good) begin
      failures++; $display("FAIL rand_hold: got %h want %h", uart_data, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
